// File: rtl/eth_axis_tx_pad_if.sv
// Header/payload input streams and serialized byte output of the Ethernet TX padder.
interface eth_axis_tx_pad_if;
   logic        s_eth_hdr_valid;
   logic        s_eth_hdr_ready;
   logic [47:0] s_eth_dest_mac;
   logic [47:0] s_eth_src_mac;
   logic [15:0] s_eth_type;
   logic [7:0]  s_eth_payload_axis_tdata;
   logic        s_eth_payload_axis_tvalid;
   logic        s_eth_payload_axis_tready;
   logic        s_eth_payload_axis_tlast;
   logic        s_eth_payload_axis_tuser;
   logic [7:0]  m_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tready;
   logic        m_axis_tlast;
   logic        m_axis_tuser;

   modport master (
      output s_eth_hdr_valid, s_eth_dest_mac, s_eth_src_mac, s_eth_type,
      output s_eth_payload_axis_tdata, s_eth_payload_axis_tvalid,
      output s_eth_payload_axis_tlast, s_eth_payload_axis_tuser, m_axis_tready,
      input  s_eth_hdr_ready, s_eth_payload_axis_tready,
      input  m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser
   );

   modport slave (
      input  s_eth_hdr_valid, s_eth_dest_mac, s_eth_src_mac, s_eth_type,
      input  s_eth_payload_axis_tdata, s_eth_payload_axis_tvalid,
      input  s_eth_payload_axis_tlast, s_eth_payload_axis_tuser, m_axis_tready,
      output s_eth_hdr_ready, s_eth_payload_axis_tready,
      output m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser
   );
endinterface

// File: rtl/eth_axis_tx_pad.sv
// Serializes header + payload into one byte stream, zero-padding short frames to MIN_FRAME_LENGTH.
// Byte 0 leaves one cycle after the header handshake; output reg + skid reg absorb m_axis backpressure.
module eth_axis_tx_pad #(
   parameter int unsigned ENABLE_PADDING   = 1,
   parameter int unsigned MIN_FRAME_LENGTH = 60
) (
   input  logic             clk,
   input  logic             rst,
   eth_axis_tx_pad_if.slave bus,
   output logic             busy
);
   typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, PAD} state_t;

   typedef struct packed {
      logic [47:0] dest_mac;
      logic [47:0] src_mac;
      logic [15:0] eth_type;
   } hdr_t;

   typedef struct packed {
      logic [7:0] dat;
      logic       last;
      logic       user;
   } beat_t;

   state_t       state, state_nxt;
   hdr_t         hdr_q;
   logic [111:0] hdr_flat;
   logic [15:0]  cnt, cnt_nxt, cnt_inc;
   logic [3:0]   hidx;
   logic         user_q, user_nxt;
   logic         rdy_en;
   beat_t        out_q, skid_q, push_beat;
   logic         out_vld, skid_vld, push_vld;
   logic         stage_rdy, hdr_fire, last_push, pad_short, pad_done;

   assign stage_rdy = !skid_vld;
   assign cnt_inc   = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
   assign pad_short = (ENABLE_PADDING != 0) && (({16'd0, cnt} + 32'd1) < MIN_FRAME_LENGTH);
   assign pad_done  = (({16'd0, cnt} + 32'd1) == MIN_FRAME_LENGTH);
   assign hidx      = 4'd13 - cnt[3:0];
   assign hdr_flat  = hdr_q;

   // The next header is also taken while the final byte is pushed, so back-to-back frames have no gap.
   assign last_push = stage_rdy &&
      ((state == PAYLOAD && bus.s_eth_payload_axis_tvalid && bus.s_eth_payload_axis_tlast && !pad_short) ||
       (state == PAD && pad_done));
   assign bus.s_eth_hdr_ready = rdy_en && (state == IDLE || last_push);
   assign hdr_fire            = bus.s_eth_hdr_valid && bus.s_eth_hdr_ready;

   assign bus.m_axis_tvalid = out_vld;
   assign bus.m_axis_tdata  = out_q.dat;
   assign bus.m_axis_tlast  = out_q.last;
   assign bus.m_axis_tuser  = out_q.user;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      user_nxt  = user_q;
      push_vld  = 1'b0;
      push_beat = '0;
      bus.s_eth_payload_axis_tready = 1'b0;
      case (state)
         HEADER: begin
            if (stage_rdy) begin
               push_vld      = 1'b1;
               push_beat.dat = hdr_flat[{hidx, 3'b000} +: 8];
               cnt_nxt       = cnt_inc;
               if (cnt == 16'd13) state_nxt = PAYLOAD;
            end
         end
         PAYLOAD: begin
            bus.s_eth_payload_axis_tready = stage_rdy;
            if (stage_rdy && bus.s_eth_payload_axis_tvalid) begin
               push_vld      = 1'b1;
               push_beat.dat = bus.s_eth_payload_axis_tdata;
               cnt_nxt       = cnt_inc;
               if (bus.s_eth_payload_axis_tlast) begin
                  user_nxt = bus.s_eth_payload_axis_tuser;
                  if (pad_short) begin
                     state_nxt = PAD;
                  end else begin
                     push_beat.last = 1'b1;
                     push_beat.user = bus.s_eth_payload_axis_tuser;
                     state_nxt      = IDLE;
                  end
               end
            end
         end
         PAD: begin
            if (stage_rdy) begin
               push_vld = 1'b1;
               cnt_nxt  = cnt_inc;
               if (pad_done) begin
                  push_beat.last = 1'b1;
                  push_beat.user = user_q;
                  state_nxt      = IDLE;
               end
            end
         end
         default: ;
      endcase
      if (hdr_fire) begin
         state_nxt = HEADER;
         cnt_nxt   = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= IDLE;
         cnt      <= '0;
         hdr_q    <= '0;
         user_q   <= 1'b0;
         rdy_en   <= 1'b0;
         busy     <= 1'b0;
         out_vld  <= 1'b0;
         out_q    <= '0;
         skid_vld <= 1'b0;
         skid_q   <= '0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         user_q <= user_nxt;
         rdy_en <= 1'b1;
         if (hdr_fire)
            hdr_q <= {bus.s_eth_dest_mac, bus.s_eth_src_mac, bus.s_eth_type};
         // A tlast leaving while a newer frame is already underway must not drop busy.
         if (hdr_fire)
            busy <= 1'b1;
         else if (state == IDLE && out_vld && out_q.last && bus.m_axis_tready)
            busy <= 1'b0;
         if (!out_vld || bus.m_axis_tready) begin
            if (skid_vld) begin
               out_vld  <= 1'b1;
               out_q    <= skid_q;
               skid_vld <= 1'b0;
            end else begin
               out_vld <= push_vld;
               out_q   <= push_beat;
            end
         end else if (push_vld) begin
            skid_vld <= 1'b1;
            skid_q   <= push_beat;
         end
      end
   end
endmodule

// File: tb/tb_eth_axis_tx_pad.sv
// Scoreboard bench for eth_axis_tx_pad: stimulus queues expected beats, a negedge monitor checks them.
module tb_eth_axis_tx_pad;
   typedef struct packed {
      logic [7:0] dat;
      logic       last;
      logic       user;
   } beat_t;

   logic  clk = 1'b0;
   logic  rst = 1'b0;
   logic  busy;
   logic  bp_en = 1'b0;
   beat_t exp_q[$];
   beat_t held;
   logic  held_vld = 1'b0;
   int    tests = 0, fails = 0;
   int    cur_run = 0, max_run = 0, busy_low_vld = 0, beat_idx = 0;

   eth_axis_tx_pad_if bus();

   eth_axis_tx_pad #(.ENABLE_PADDING(1), .MIN_FRAME_LENGTH(60)) dut (
      .clk  (clk),
      .rst  (rst),
      .bus  (bus),
      .busy (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic void expect_frame(input logic [47:0] da, input logic [47:0] sa,
                                        input logic [15:0] ty, input int n,
                                        input logic [7:0] base, input logic user);
      logic [111:0] h;
      int           total;
      beat_t        b;
      h     = {da, sa, ty};
      total = (14 + n < 60) ? 60 : 14 + n;
      for (int i = 0; i < total; i++) begin
         if (i < 14)          b.dat = h[111 - 8*i -: 8];
         else if (i < 14 + n) b.dat = base + 8'(i - 14);
         else                 b.dat = 8'h00;
         b.last = (i == total - 1);
         b.user = b.last && user;
         exp_q.push_back(b);
      end
   endfunction

   task automatic send_hdr(input logic [47:0] da, input logic [47:0] sa, input logic [15:0] ty,
                           output int k);
      k = 0;
      bus.s_eth_dest_mac  = da;
      bus.s_eth_src_mac   = sa;
      bus.s_eth_type      = ty;
      bus.s_eth_hdr_valid = 1'b1;
      do begin
         @(negedge clk);
         k++;
      end while (!bus.s_eth_hdr_ready && k < 1000);
      if (!bus.s_eth_hdr_ready) begin
         tests++;
         fails++;
         $display("FAIL hdr_wait: no hdr_ready after %0d cycles, expected handshake", k);
      end
      @(posedge clk); #1;
      bus.s_eth_hdr_valid = 1'b0;
      bus.s_eth_dest_mac  = '1;
      bus.s_eth_src_mac   = 48'h0BAD_0BAD_0BAD;
      bus.s_eth_type      = 16'hFFFF;
   endtask

   task automatic send_payload(input int n, input logic [7:0] base, input logic user,
                               input logic with_last, input logic gaps);
      int k;
      for (int i = 0; i < n; i++) begin
         if (gaps && $urandom_range(0, 1) == 1) begin
            bus.s_eth_payload_axis_tvalid = 1'b0;
            repeat ($urandom_range(1, 2)) begin @(posedge clk); #1; end
         end
         bus.s_eth_payload_axis_tdata  = base + 8'(i);
         bus.s_eth_payload_axis_tlast  = with_last && (i == n - 1);
         bus.s_eth_payload_axis_tuser  = (with_last && i == n - 1) ? user : 1'($urandom_range(0, 1));
         bus.s_eth_payload_axis_tvalid = 1'b1;
         k = 0;
         do begin
            @(negedge clk);
            k++;
         end while (!bus.s_eth_payload_axis_tready && k < 1000);
         if (!bus.s_eth_payload_axis_tready) begin
            tests++;
            fails++;
            $display("FAIL payload_wait: no tready for byte %0d, expected handshake", i);
         end
         @(posedge clk); #1;
      end
      bus.s_eth_payload_axis_tvalid = 1'b0;
      bus.s_eth_payload_axis_tlast  = 1'b0;
      bus.s_eth_payload_axis_tuser  = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      int k = 0;
      while (exp_q.size() != 0 && k < 3000) begin
         @(negedge clk);
         k++;
      end
      check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
      @(negedge clk);
      check({name, "_busy_clr"}, 32'(busy), 32'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      bus.m_axis_tready = 1'b1;
      forever begin
         @(posedge clk); #1;
         bus.m_axis_tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Monitor: pops the scoreboard on every handshake and checks held beats stay put.
   always @(negedge clk) begin
      beat_t cur, e;
      cur = {bus.m_axis_tdata, bus.m_axis_tlast, bus.m_axis_tuser};
      if (rst) begin
         if (bus.m_axis_tvalid) begin
            cur_run++;
            if (cur_run > max_run) max_run = cur_run;
            if (!busy) busy_low_vld++;
         end else begin
            cur_run = 0;
         end
         if (held_vld)
            check("hold_stable", 32'({bus.m_axis_tvalid, cur}), 32'({1'b1, held}));
         held_vld = bus.m_axis_tvalid && !bus.m_axis_tready;
         held     = cur;
         if (bus.m_axis_tvalid && bus.m_axis_tready) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_beat: got %h, expected no beat", cur);
            end else begin
               e = exp_q.pop_front();
               check($sformatf("beat%0d", beat_idx), 32'(cur), 32'(e));
            end
            beat_idx++;
         end
      end else begin
         held_vld = 1'b0;
         cur_run  = 0;
      end
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      fails++;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $fatal(1);
   end

   initial begin
      int k;
      bus.s_eth_hdr_valid           = 1'b0;
      bus.s_eth_dest_mac            = '0;
      bus.s_eth_src_mac             = '0;
      bus.s_eth_type                = '0;
      bus.s_eth_payload_axis_tdata  = '0;
      bus.s_eth_payload_axis_tvalid = 1'b0;
      bus.s_eth_payload_axis_tlast  = 1'b0;
      bus.s_eth_payload_axis_tuser  = 1'b0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_tvalid", 32'(bus.m_axis_tvalid), 32'd0);
      check("rst_tdata", 32'(bus.m_axis_tdata), 32'd0);
      check("rst_tlast", 32'(bus.m_axis_tlast), 32'd0);
      check("rst_tuser", 32'(bus.m_axis_tuser), 32'd0);
      check("rst_hdr_ready", 32'(bus.s_eth_hdr_ready), 32'd0);
      check("rst_pay_ready", 32'(bus.s_eth_payload_axis_tready), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      check("rel_hdr_ready_low", 32'(bus.s_eth_hdr_ready), 32'd0);
      @(posedge clk); #1;
      check("rel_hdr_ready_high", 32'(bus.s_eth_hdr_ready), 32'd1);

      // Short frame: 10 bytes padded to 60, plus first-byte latency.
      expect_frame(48'hDA0203040506, 48'h5A5152535455, 16'h8000, 10, 8'h00, 1'b0);
      send_hdr(48'hDA0203040506, 48'h5A5152535455, 16'h8000, k);
      check("lat_pre_vld", 32'(bus.m_axis_tvalid), 32'd0);
      check("busy_set", 32'(busy), 32'd1);
      @(posedge clk); #1;
      check("lat_vld", 32'(bus.m_axis_tvalid), 32'd1);
      check("lat_byte0", 32'(bus.m_axis_tdata), 32'hDA);
      send_payload(10, 8'h00, 1'b0, 1'b1, 1'b0);
      wait_drain("short");

      expect_frame(48'h112233445566, 48'h778899AABBCC, 16'h0800, 46, 8'h40, 1'b0);
      send_hdr(48'h112233445566, 48'h778899AABBCC, 16'h0800, k);
      send_payload(46, 8'h40, 1'b0, 1'b1, 1'b0);
      wait_drain("exact");

      expect_frame(48'hFFFFFFFFFFFF, 48'h020000000001, 16'h0806, 100, 8'h80, 1'b0);
      send_hdr(48'hFFFFFFFFFFFF, 48'h020000000001, 16'h0806, k);
      send_payload(100, 8'h80, 1'b0, 1'b1, 1'b0);
      wait_drain("long");

      expect_frame(48'hA1A2A3A4A5A6, 48'hB1B2B3B4B5B6, 16'h86DD, 1, 8'h77, 1'b1);
      send_hdr(48'hA1A2A3A4A5A6, 48'hB1B2B3B4B5B6, 16'h86DD, k);
      send_payload(1, 8'h77, 1'b1, 1'b1, 1'b0);
      wait_drain("bad");

      bp_en = 1'b1;
      expect_frame(48'hDA0203040506, 48'h5A5152535455, 16'h8000, 10, 8'h00, 1'b0);
      send_hdr(48'hDA0203040506, 48'h5A5152535455, 16'h8000, k);
      send_payload(10, 8'h00, 1'b0, 1'b1, 1'b1);
      expect_frame(48'h0C0D0E0F1011, 48'h121314151617, 16'h88B5, 50, 8'h20, 1'b1);
      send_hdr(48'h0C0D0E0F1011, 48'h121314151617, 16'h88B5, k);
      send_payload(50, 8'h20, 1'b1, 1'b1, 1'b1);
      wait_drain("bp");
      bp_en = 1'b0;
      @(posedge clk); #1;

      // Back-to-back: second header must be taken during the last pad push.
      cur_run = 0;
      max_run = 0;
      expect_frame(48'h010203040506, 48'h0A0B0C0D0E0F, 16'h8100, 10, 8'h30, 1'b0);
      expect_frame(48'h060504030201, 48'h0F0E0D0C0B0A, 16'h8100, 10, 8'h50, 1'b0);
      send_hdr(48'h010203040506, 48'h0A0B0C0D0E0F, 16'h8100, k);
      send_payload(10, 8'h30, 1'b0, 1'b1, 1'b0);
      send_hdr(48'h060504030201, 48'h0F0E0D0C0B0A, 16'h8100, k);
      check("b2b_hdr_wait", 32'(k), 32'd36);
      send_payload(10, 8'h50, 1'b0, 1'b1, 1'b0);
      wait_drain("b2b");
      check("b2b_run", 32'(max_run), 32'd120);

      // Reset during payload byte 5, then a clean frame.
      expect_frame(48'hDEADBEEF0001, 48'hCAFEF00D0002, 16'h0800, 30, 8'h00, 1'b0);
      send_hdr(48'hDEADBEEF0001, 48'hCAFEF00D0002, 16'h0800, k);
      send_payload(5, 8'h00, 1'b0, 1'b0, 1'b0);
      bus.s_eth_payload_axis_tdata  = 8'h05;
      bus.s_eth_payload_axis_tvalid = 1'b1;
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      bus.s_eth_payload_axis_tvalid = 1'b0;
      exp_q.delete();
      check("mid_rst_tvalid", 32'(bus.m_axis_tvalid), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_hdr_ready", 32'(bus.s_eth_hdr_ready), 32'd0);
      @(posedge clk); #1;
      check("post_rst_hdr_ready", 32'(bus.s_eth_hdr_ready), 32'd1);
      expect_frame(48'h5E0000000042, 48'h5A5152535455, 16'h0800, 20, 8'hA0, 1'b0);
      send_hdr(48'h5E0000000042, 48'h5A5152535455, 16'h0800, k);
      send_payload(20, 8'hA0, 1'b0, 1'b1, 1'b0);
      wait_drain("post_rst");

      check("busy_low_while_vld", 32'(busy_low_vld), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
